spi_word_sync: RTL and testbench
================================

# spi_word_sync

Carries a WIDTH-bit word from the din_clk domain to the dout_clk domain using a four-phase req/ack handshake with a held data bus. It is the multi-bit companion of the SPI single-bit pulse synchronizer: the SPI side launches completed words, and the system side receives them as one-cycle valid strobes. Req and ack cross domains through crg_sync2_arst instances. The data bus itself is never synchronized; it is stable whenever the destination samples it.

## Interface
Parameters:
- WIDTH, 8, word width in bits (≥1)

Ports:
- din_clk  input  1  source-domain clock
- din_rst_n  input  1  source-domain reset, asynchronous, active-low
- dout_clk  input  1  destination-domain clock
- dout_rst_n  input  1  destination-domain reset, asynchronous, active-low
- din_valid  input  1  source strobe; din_data is accepted on a din_clk edge when din_valid=1 and din_busy=0
- din_data  input  WIDTH  source word
- din_busy  output  1  source side cannot accept a word (din_clk domain)
- din_ovf  output  1  sticky: din_valid was seen while din_busy=1 (din_clk domain)
- din_ovf_clr  input  1  clears din_ovf (din_clk domain)
- dout_valid  output  1  one-dout_clk-cycle strobe; dout_data is a new word
- dout_data  output  WIDTH  delivered word, held until the next delivery

## Operation
- Source FSM (din_clk) has three states: IDLE, REQ, ACKW.
  - IDLE → REQ when din_valid=1 and ack_s=0. On that edge din_data is captured into the hold register and req is set to 1.
  - REQ → ACKW when ack_s=1. On that edge req is set to 0.
  - ACKW → IDLE when ack_s=0.
  - ack_s is ack after a 2-flop synchronizer in din_clk.
- din_busy = (state≠IDLE) | ack_s. It is combinational from registers only.
- din_valid while din_busy=1: the word is dropped and din_ovf is set on the next edge.
- din_ovf: if set and clear occur on the same edge, set wins. Otherwise din_ovf_clr=1 clears it.
- Hold register: loaded only on IDLE→REQ. It is constant while req=1 and until ack_s returns to 0.
- Destination side (dout_clk):
  - req_s is req after a 2-flop synchronizer; req_q is req_s delayed by one cycle.
  - Rising req_s & !req_q: on the next edge, dout_data is loaded from the hold register, dout_valid=1 for one cycle, and ack is set to 1.
  - Falling !req_s & req_q: on the next edge, ack is set to 0.
  - dout_valid fires exactly once per accepted word.
- Arithmetic: none. Data passes through bit-exact; there is no width conversion.
- Reset values:
  - Source domain: din_busy=0 (apart from ack_s), din_ovf=0, state IDLE, req=0, hold=0, ack_s=0.
  - Destination domain: dout_valid=0, dout_data=0, ack=0, req_s=0, req_q=0.
- Source reset mid-transfer: state returns to IDLE and req drops.
  - If ack is still 1 in the destination, din_busy stays 1 until ack_s=0.
  - No new word is launched before that, so no handshake corruption occurs.
- Destination reset mid-transfer: ack is cleared.
  - If req is still 1 after release, req_s rises again and the held word is re-delivered once. This duplicate is the defined behaviour.
  - The source completes normally.
- The clocks are fully asynchronous; there is no frequency-ratio restriction.

## Timing
- Acceptance: din_valid is sampled at din_clk edge E0; req=1 after E0; din_busy=1 from E0 onward.
- Delivery latency, counted from the first dout_clk edge after req rises: req_s=1 after 2 edges, dout_valid=1 after the 3rd edge (±1 edge for synchronizer uncertainty).
- Worked example, same clock in phase, cycles counted from E0:
  - dout_valid is high in cycle 3.
  - ack_s=1 after E5; REQ→ACKW at E6.
  - req_s=0 after E8; ack=0 after E9; ack_s=0 after E11.
  - IDLE and din_busy=0 after E12.
  - Result: minimum accepted-word spacing is 12 din_clk cycles.
- dout_data changes only on the edge that asserts dout_valid.
- din_ovf updates one din_clk edge after the offending din_valid.

## Test plan
- Single word, equal 100 MHz clocks: din_data=8'hA5 with din_valid for 1 cycle → exactly one dout_valid with dout_data=8'hA5 3±1 dout cycles later; din_busy high for 12 cycles; din_ovf=0.
- Back-to-back stream, din_clk=100 MHz, dout_clk=37 MHz: 64 words 0..63, each sent when din_busy=0 → 64 dout_valid pulses, in order, values 0..63, no duplicates.
- Overflow: send 8'h11, then din_valid with 8'h22 two cycles later while busy → only 8'h11 is delivered; din_ovf=1. Pulse din_ovf_clr together with a new overflow → din_ovf stays 1; din_ovf_clr alone → din_ovf=0.
- Fast destination, dout_clk=8×din_clk: 16 random words → all delivered; dout_data stable between dout_valid pulses.
- Source reset while in REQ after ack=1: assert din_rst_n for 2 cycles → din_busy stays 1 until ack_s=0, then the next word (8'h5A) is delivered exactly once.
- Destination reset while req=1 and before ack: hold dout_rst_n low for 3 cycles → after release, one dout_valid with the held word; the source returns to IDLE; no further pulses.

Source files
------------

// File: rtl/spi_word_sync_if.sv
// Handshake and data signals of the SPI word synchronizer, both clock domains.
// master drives the source side and observes the destination side; slave is the synchronizer.
interface spi_word_sync_if #(
    parameter int WIDTH = 8
);
    logic             din_valid;
    logic [WIDTH-1:0] din_data;
    logic             din_busy;
    logic             din_ovf;
    logic             din_ovf_clr;
    logic             dout_valid;
    logic [WIDTH-1:0] dout_data;

    modport master (
        output din_valid, din_data, din_ovf_clr,
        input  din_busy, din_ovf, dout_valid, dout_data
    );

    modport slave (
        input  din_valid, din_data, din_ovf_clr,
        output din_busy, din_ovf, dout_valid, dout_data
    );
endinterface

// File: rtl/spi_word_sync.sv
// Multi-bit CDC: four-phase req/ack handshake moving one held WIDTH-bit word
// from din_clk to dout_clk; only req and ack pass through 2-flop synchronizers.
module crg_sync2_arst (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

module spi_word_sync #(
    parameter int WIDTH = 8
) (
    input  logic            din_clk,
    input  logic            din_rst_n,
    input  logic            dout_clk,
    input  logic            dout_rst_n,
    spi_word_sync_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKW} state_t;

    state_t           state_q, state_d;
    logic             req_q, req_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             ack_s;
    logic             busy;

    logic             req_s, req_dly_q;
    logic             ack_q;
    logic             dvld_q;
    logic [WIDTH-1:0] ddata_q;

    // ---------------- source domain ----------------
    crg_sync2_arst u_ack_sync (
        .clk_i   (din_clk),
        .rst_n_i (din_rst_n),
        .d_i     (ack_q),
        .q_o     (ack_s)
    );

    // ack_s keeps us busy after a source reset until the destination lets go
    assign busy = (state_q != S_IDLE) | ack_s;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        hold_d  = hold_q;
        ovf_d   = ovf_q;
        if (bus.din_ovf_clr) ovf_d = 1'b0;
        if (bus.din_valid && busy) ovf_d = 1'b1;
        unique case (state_q)
            S_IDLE: if (bus.din_valid && !ack_s) begin
                state_d = S_REQ;
                req_d   = 1'b1;
                hold_d  = bus.din_data;
            end
            S_REQ: if (ack_s) begin
                state_d = S_ACKW;
                req_d   = 1'b0;
            end
            S_ACKW: if (!ack_s) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge din_clk or negedge din_rst_n) begin
        if (!din_rst_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.din_busy = busy;
    assign bus.din_ovf  = ovf_q;

    // ---------------- destination domain ----------------
    crg_sync2_arst u_req_sync (
        .clk_i   (dout_clk),
        .rst_n_i (dout_rst_n),
        .d_i     (req_q),
        .q_o     (req_s)
    );

    // hold_q is quiet here: it only moves in IDLE, while req and ack are both low
    always_ff @(posedge dout_clk or negedge dout_rst_n) begin
        if (!dout_rst_n) begin
            req_dly_q <= 1'b0;
            ack_q     <= 1'b0;
            dvld_q    <= 1'b0;
            ddata_q   <= '0;
        end else begin
            req_dly_q <= req_s;
            dvld_q    <= 1'b0;
            if (req_s && !req_dly_q) begin
                ddata_q <= hold_q;
                dvld_q  <= 1'b1;
                ack_q   <= 1'b1;
            end else if (!req_s && req_dly_q) begin
                ack_q   <= 1'b0;
            end
        end
    end

    assign bus.dout_valid = dvld_q;
    assign bus.dout_data  = ddata_q;
endmodule

// File: tb/tb_spi_word_sync.sv
// Randomized bench: a queue of accepted words is the reference; every delivered
// word must match in order, exactly once, with dout_data steady in between.
`timescale 1ns/1ps
module tb_spi_word_sync;
    localparam int W = 8;

    logic din_clk = 1'b0, dout_clk = 1'b0;
    logic din_rst_n = 1'b0, dout_rst_n = 1'b0;
    real  din_half = 5.0, dout_half = 5.0;

    always #(din_half)  din_clk  = ~din_clk;
    always #(dout_half) dout_clk = ~dout_clk;

    spi_word_sync_if #(.WIDTH(W)) bus ();

    spi_word_sync #(.WIDTH(W)) dut (
        .din_clk    (din_clk),
        .din_rst_n  (din_rst_n),
        .dout_clk   (dout_clk),
        .dout_rst_n (dout_rst_n),
        .bus        (bus)
    );

    int checks = 0, errors = 0;
    int deliveries = 0, sent = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_data = '0;
    logic         prev_vld = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // destination-side compare against the reference queue
    always @(negedge dout_clk) begin
        if (!dout_rst_n) begin
            last_data = '0;
            prev_vld  = 1'b0;
        end else begin
            if (bus.dout_valid) begin
                deliveries++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_delivery: got %0h expected none at %0t", bus.dout_data, $time);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    if (bus.dout_data !== e) begin
                        errors++;
                        $display("FAIL delivered_word: got %0h expected %0h at %0t", bus.dout_data, e, $time);
                    end
                end
                chk("single_cycle_valid", {31'b0, prev_vld}, 32'd0);
                last_data = bus.dout_data;
            end else begin
                chk("dout_data_stable", {24'b0, bus.dout_data}, {24'b0, last_data});
            end
            prev_vld = bus.dout_valid;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge din_clk);
        #1;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (bus.din_busy === 1'b1 && t < 400) begin
            cyc(1);
            t++;
        end
        if (t >= 400) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    // returns one edge after acceptance, #1 past the edge
    task automatic send_word(input logic [W-1:0] w);
        wait_idle();
        bus.din_valid = 1'b1;
        bus.din_data  = w;
        exp_q.push_back(w);
        sent++;
        cyc(1);
        bus.din_valid = 1'b0;
        chk("busy_after_accept", {31'b0, bus.din_busy}, 32'd1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.din_busy === 1'b1) && t < 2000) begin
            cyc(1);
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int n_busy, k;
        bus.din_valid   = 1'b0;
        bus.din_data    = '0;
        bus.din_ovf_clr = 1'b0;
        #23;
        chk("rst_busy", {31'b0, bus.din_busy}, 32'd0);
        chk("rst_ovf", {31'b0, bus.din_ovf}, 32'd0);
        chk("rst_dout_valid", {31'b0, bus.dout_valid}, 32'd0);
        chk("rst_dout_data", {24'b0, bus.dout_data}, 32'd0);
        din_rst_n = 1'b1;
        dout_rst_n = 1'b1;
        cyc(3);

        // single word, equal in-phase clocks
        send_word(8'hA5);
        n_busy = 1;
        k = 0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    cyc(1);
                    if (!bus.din_busy) break;
                    n_busy++;
                end
            end
            begin
                for (int i = 0; i < 20; i++) begin
                    cyc(1);
                    k++;
                    if (bus.dout_valid) break;
                end
            end
        join
        chk("busy_cycles", n_busy, 32'd12);
        chk("latency_3pm1", {31'b0, (k >= 2 && k <= 4)}, 32'd1);
        chk("last_word_a5", {24'b0, last_data}, 32'hA5);
        chk("ovf_single", {31'b0, bus.din_ovf}, 32'd0);
        drain();

        // back-to-back stream into a slower destination
        dout_half = 13.5;
        cyc(4);
        for (int i = 0; i < 64; i++) send_word(W'(i));
        drain();
        chk("stream_count", deliveries, sent);

        // overflow and sticky clear priority
        dout_half = 5.0;
        cyc(4);
        send_word(8'h11);
        cyc(1);
        bus.din_valid = 1'b1;
        bus.din_data  = 8'h22;
        cyc(1);
        bus.din_valid = 1'b0;
        chk("ovf_set", {31'b0, bus.din_ovf}, 32'd1);
        drain();
        chk("ovf_sticky", {31'b0, bus.din_ovf}, 32'd1);
        send_word(8'h33);
        bus.din_valid   = 1'b1;
        bus.din_data    = 8'h44;
        bus.din_ovf_clr = 1'b1;
        cyc(1);
        bus.din_valid = 1'b0;
        chk("ovf_set_wins", {31'b0, bus.din_ovf}, 32'd1);
        cyc(1);
        bus.din_ovf_clr = 1'b0;
        chk("ovf_cleared", {31'b0, bus.din_ovf}, 32'd0);
        drain();

        // fast destination, random words
        dout_half = 0.625;
        cyc(4);
        for (int i = 0; i < 16; i++) send_word(W'($urandom_range(0, 255)));
        drain();
        chk("fast_count", deliveries, sent);

        // source reset after the destination has acked
        dout_half = 5.0;
        cyc(4);
        send_word(W'($urandom_range(0, 255)));
        k = 0;
        while (!bus.dout_valid && k < 50) begin
            cyc(1);
            k++;
        end
        chk("pre_srst_delivery", {31'b0, (k < 50)}, 32'd1);
        din_rst_n = 1'b0;
        cyc(2);
        din_rst_n = 1'b1;
        cyc(30);
        send_word(8'h5A);
        drain();
        chk("srst_5a_once", {24'b0, last_data}, 32'h5A);
        chk("srst_count", deliveries, sent);

        // destination reset before the request is seen: one delivery after release
        send_word(8'h77);
        @(posedge dout_clk);
        #0.2 dout_rst_n = 1'b0;
        repeat (3) @(posedge dout_clk);
        #0.2 dout_rst_n = 1'b1;
        drain();
        chk("drst_word", {24'b0, last_data}, 32'h77);
        chk("drst_idle", {31'b0, bus.din_busy}, 32'd0);
        cyc(40);
        chk("final_count", deliveries, sent);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
